// File: rtl/comp_pkg.sv
// Shared types and constants for the hysteresis comparator.
package comp_pkg;

    // Tracker state: ST_INIT until the first valid sample picks a side.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_BELOW = 2'd1,
        ST_ABOVE = 2'd2
    } comp_state_e;

    // Width of the crossing counter output.
    localparam int CROSS_CNT_W = 16;

endpackage

// File: rtl/comp_core.sv
// Combinational compare core: extends operands to WIDTH+2 bits so that
// b+hyst and b-hyst never wrap, then produces the raw flags and the two
// hysteresis qualification terms.
module comp_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hyst,
    input  logic             signed_mode,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             qual_rise,
    output logic             qual_fall
);

    localparam int EW = WIDTH + 2;

    logic signed [EW-1:0] a_ext;
    logic signed [EW-1:0] b_ext;
    logic signed [EW-1:0] hyst_ext;
    logic signed [EW-1:0] b_hi;
    logic signed [EW-1:0] b_lo;

    // Operand extension and hysteresis window edges in widened arithmetic.
    always_comb begin
        a_ext    = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        b_ext    = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
        hyst_ext = {2'b00, hyst};
        b_hi     = b_ext + hyst_ext;
        b_lo     = b_ext - hyst_ext;
    end

    assign gt        = (a_ext > b_ext);
    assign lt        = (a_ext < b_ext);
    assign eq        = (a_ext == b_ext);
    assign qual_rise = (a_ext > b_hi);
    assign qual_fall = (a_ext < b_lo);

endmodule

// File: rtl/comp_hyst.sv
// Streaming magnitude comparator with hysteresis and debounce.
// Raw flags are registered copies of the compare; a three-state tracker
// produces a debounced 'above' level plus one-cycle rise/fall pulses.
// Optional feature: define COMP_CROSS_CNT_EN to build a saturating
// crossing counter on cross_cnt; otherwise cross_cnt is tied to 0.
module comp_hyst
    import comp_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [WIDTH-1:0]       hyst,
    input  logic                   signed_mode,
    output logic                   out_valid,
    output logic                   gt,
    output logic                   lt,
    output logic                   eq,
    output logic                   above,
    output logic                   rise,
    output logic                   fall,
    output logic [CROSS_CNT_W-1:0] cross_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic core_gt, core_lt, core_eq, qual_rise, qual_fall;

    comp_state_e      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             above_next, rise_next, fall_next;

    comp_core #(.WIDTH(WIDTH)) u_core (
        .a           (a),
        .b           (b),
        .hyst        (hyst),
        .signed_mode (signed_mode),
        .gt          (core_gt),
        .lt          (core_lt),
        .eq          (core_eq),
        .qual_rise   (qual_rise),
        .qual_fall   (qual_fall)
    );

    // Raw flag pipeline: out_valid follows in_valid, flags hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                gt <= core_gt;
                lt <= core_lt;
                eq <= core_eq;
            end
        end
    end

    // Tracker next-state: debounce qualifying samples, toggle on the last one.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        above_next = above;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (in_valid) begin
            case (state)
                ST_INIT: begin
                    state_next = core_gt ? ST_ABOVE : ST_BELOW;
                    above_next = core_gt;
                    cnt_next   = '0;
                end
                ST_BELOW: begin
                    if (!qual_rise) begin
                        cnt_next = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = ST_ABOVE;
                        above_next = 1'b1;
                        rise_next  = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ST_ABOVE: begin
                    if (!qual_fall) begin
                        cnt_next = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = ST_BELOW;
                        above_next = 1'b0;
                        fall_next  = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_INIT;
                    above_next = 1'b0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Tracker state register and registered level/pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
            above <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            above <= above_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

`ifdef COMP_CROSS_CNT_EN
    logic [CROSS_CNT_W-1:0] cross_reg;

    // Saturating count of debounced crossings, updated with the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cross_reg <= '0;
        end else if ((rise_next || fall_next) && (cross_reg != '1)) begin
            cross_reg <= cross_reg + 1'b1;
        end
    end

    assign cross_cnt = cross_reg;
`else
    assign cross_cnt = '0;
`endif

endmodule

// File: tb/tb_comp_hyst.sv
// Self-checking bench for comp_hyst (WIDTH=8, DEBOUNCE=3): directed
// scenarios plus randomized traffic against an integer reference model.
module tb_comp_hyst;

    localparam int W   = 8;
    localparam int DEB = 3;
`ifdef COMP_CROSS_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0, b = '0, hyst = '0;
    logic         signed_mode = 1'b0;
    logic         out_valid, gt, lt, eq, above, rise, fall;
    logic [15:0]  cross_cnt;

    comp_hyst #(.WIDTH(W), .DEBOUNCE(DEB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .hyst(hyst),
        .signed_mode(signed_mode), .out_valid(out_valid), .gt(gt), .lt(lt),
        .eq(eq), .above(above), .rise(rise), .fall(fall), .cross_cnt(cross_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: side 0 = not yet decided, 1 = below, 2 = above.
    int m_side, m_run, m_cross;
    bit m_ov, m_gt, m_lt, m_eq, m_above, m_rise, m_fall;

    function automatic int value_of(input logic [W-1:0] x, input bit s);
        return s ? int'($signed(x)) : int'(x);
    endfunction

    task automatic model_reset();
        m_side = 0; m_run = 0; m_cross = 0;
        m_ov = 0; m_gt = 0; m_lt = 0; m_eq = 0;
        m_above = 0; m_rise = 0; m_fall = 0;
    endtask

    task automatic model_sample(input bit v, input logic [W-1:0] ta, tb, th, input bit ts);
        int av, bv, hv;
        bit qual;
        m_ov = v; m_rise = 0; m_fall = 0;
        if (!v) return;
        av = value_of(ta, ts); bv = value_of(tb, ts); hv = int'(th);
        m_gt = av > bv; m_lt = av < bv; m_eq = av == bv;
        if (m_side == 0) begin
            m_side = (av > bv) ? 2 : 1;
            m_above = (m_side == 2);
            m_run = 0;
            return;
        end
        qual = (m_side == 1) ? (av > bv + hv) : (av < bv - hv);
        if (!qual) begin
            m_run = 0;
            return;
        end
        m_run++;
        if (m_run == DEB) begin
            m_run = 0;
            if (m_side == 1) begin m_side = 2; m_rise = 1; end
            else             begin m_side = 1; m_fall = 1; end
            m_above = (m_side == 2);
            if (CNT_ON && m_cross < 65535) m_cross++;
        end
    endtask

    // Drive one cycle starting at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input logic [W-1:0] ta, tb, th, input bit ts);
        in_valid = v; a = ta; b = tb; hyst = th; signed_mode = ts;
        @(posedge clk);
        model_sample(v, ta, tb, th, ts);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0;
        rst = 1; #1; model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; #1; model_reset();
        n_cmp++;
        if ({out_valid, gt, lt, eq, above, rise, fall} !== 7'b0 || cross_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: got flags=%b cross=%0d, want all 0",
                     {out_valid, gt, lt, eq, above, rise, fall}, cross_cnt);
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_raw_unsigned();
        do_reset();
        step(1, 8'd5, 8'd9, 8'd0, 0);
        n_cmp++;
        if ({out_valid, gt, lt, eq} !== 4'b1010) begin
            n_bad++; $display("FAIL raw_lt: got ov/gt/lt/eq=%b want 1010", {out_valid, gt, lt, eq});
        end
        step(1, 8'd9, 8'd9, 8'd0, 0);
        n_cmp++;
        if ({out_valid, gt, lt, eq} !== 4'b1001) begin
            n_bad++; $display("FAIL raw_eq: got ov/gt/lt/eq=%b want 1001", {out_valid, gt, lt, eq});
        end
        step(0, 8'd200, 8'd1, 8'd0, 0);
        n_cmp++;
        if ({out_valid, gt, lt, eq} !== 4'b0001) begin
            n_bad++; $display("FAIL raw_hold: got ov/gt/lt/eq=%b want 0001", {out_valid, gt, lt, eq});
        end
    endtask

    task automatic test_signed();
        step(1, 8'hFF, 8'h01, 8'd0, 1);
        n_cmp++;
        if ({gt, lt, eq} !== 3'b010) begin
            n_bad++; $display("FAIL signed_lt: got gt/lt/eq=%b want 010", {gt, lt, eq});
        end
        step(1, 8'hFF, 8'h01, 8'd0, 0);
        n_cmp++;
        if ({gt, lt, eq} !== 3'b100) begin
            n_bad++; $display("FAIL unsigned_gt: got gt/lt/eq=%b want 100", {gt, lt, eq});
        end
    endtask

    task automatic test_init();
        do_reset();
        step(1, 8'd20, 8'd10, 8'd0, 0);
        n_cmp++;
        if (above !== 1'b1 || rise !== 1'b0 || fall !== 1'b0 || cross_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL init_above: got above=%b rise=%b fall=%b cross=%0d want 1 0 0 0",
                     above, rise, fall, cross_cnt);
        end
    endtask

    task automatic test_hyst_debounce();
        do_reset();
        step(1, 8'd0, 8'd100, 8'd4, 0);
        for (int i = 0; i < 3; i++) step(1, 8'd104, 8'd100, 8'd4, 0);
        n_cmp++;
        if (above !== 1'b0 || rise !== 1'b0) begin
            n_bad++; $display("FAIL edge_no_qual: got above=%b rise=%b want 0 0", above, rise);
        end
        step(1, 8'd105, 8'd100, 8'd4, 0);
        step(1, 8'd105, 8'd100, 8'd4, 0);
        step(1, 8'd103, 8'd100, 8'd4, 0);
        step(1, 8'd105, 8'd100, 8'd4, 0);
        step(1, 8'd105, 8'd100, 8'd4, 0);
        n_cmp++;
        if (above !== 1'b0 || rise !== 1'b0) begin
            n_bad++; $display("FAIL debounce_clear: got above=%b rise=%b want 0 0", above, rise);
        end
        step(1, 8'd105, 8'd100, 8'd4, 0);
        n_cmp++;
        if (rise !== 1'b1 || fall !== 1'b0 || above !== 1'b1 || cross_cnt !== 16'(CNT_ON)) begin
            n_bad++;
            $display("FAIL rise_third: got rise=%b fall=%b above=%b cross=%0d want 1 0 1 %0d",
                     rise, fall, above, cross_cnt, CNT_ON);
        end
        step(0, 8'd105, 8'd100, 8'd4, 0);
        n_cmp++;
        if (rise !== 1'b0 || above !== 1'b1) begin
            n_bad++; $display("FAIL rise_one_cycle: got rise=%b above=%b want 0 1", rise, above);
        end
    endtask

    task automatic test_no_wrap();
        do_reset();
        step(1, 8'd0, 8'd250, 8'd10, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 8'd255, 8'd250, 8'd10, 0);
            n_cmp++;
            if (rise !== 1'b0 || above !== 1'b0) begin
                n_bad++; $display("FAIL nowrap_hi[%0d]: got rise=%b above=%b want 0 0", i, rise, above);
            end
        end
        do_reset();
        step(1, 8'd200, 8'd5, 8'd10, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 8'd0, 8'd5, 8'd10, 0);
            n_cmp++;
            if (fall !== 1'b0 || above !== 1'b1) begin
                n_bad++; $display("FAIL nowrap_lo[%0d]: got fall=%b above=%b want 0 1", i, fall, above);
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        step(1, 8'd0, 8'd100, 8'd4, 0);
        step(1, 8'd105, 8'd100, 8'd4, 0);
        step(0, 8'd0, 8'd100, 8'd4, 0);
        step(1, 8'd105, 8'd100, 8'd4, 0);
        step(0, 8'd0, 8'd100, 8'd4, 0);
        step(0, 8'd0, 8'd100, 8'd4, 0);
        n_cmp++;
        if (rise !== 1'b0 || above !== 1'b0) begin
            n_bad++; $display("FAIL gaps_pending: got rise=%b above=%b want 0 0", rise, above);
        end
        step(1, 8'd105, 8'd100, 8'd4, 0);
        n_cmp++;
        if (rise !== 1'b1 || above !== 1'b1) begin
            n_bad++; $display("FAIL gaps_switch: got rise=%b above=%b want 1 1", rise, above);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 8'd20, 8'd10, 8'd0, 0);
        step(1, 8'd0, 8'd100, 8'd4, 0);
        step(1, 8'd0, 8'd100, 8'd4, 0);
        #2 rst = 1; #1; model_reset();
        n_cmp++;
        if ({out_valid, gt, lt, eq, above, rise, fall} !== 7'b0 || cross_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got flags=%b cross=%0d want all 0",
                     {out_valid, gt, lt, eq, above, rise, fall}, cross_cnt);
        end
        @(negedge clk); rst = 0;
        step(1, 8'd200, 8'd100, 8'd4, 0);
        n_cmp++;
        if (above !== 1'b1 || rise !== 1'b0 || fall !== 1'b0) begin
            n_bad++; $display("FAIL reinit: got above=%b rise=%b fall=%b want 1 0 0", above, rise, fall);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, rh;
        bit rv, rs;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rv = ($urandom_range(0, 9) < 8);
            rs = (i / 150) % 2 == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
            rb = 8'($urandom_range(0, 255));
            rh = 8'($urandom_range(0, 6));
            ra = 8'(int'(rb) + int'($urandom_range(0, 24)) - 12);
            step(rv, ra, rb, rh, rs);
            n_cmp++;
            if (out_valid !== m_ov || gt !== m_gt || lt !== m_lt || eq !== m_eq ||
                above !== m_above || rise !== m_rise || fall !== m_fall ||
                cross_cnt !== 16'(m_cross) || (rise && fall)) begin
                n_bad++;
                $display("FAIL random[%0d]: got ov%b gt%b lt%b eq%b ab%b r%b f%b c%0d want ov%b gt%b lt%b eq%b ab%b r%b f%b c%0d",
                         i, out_valid, gt, lt, eq, above, rise, fall, cross_cnt,
                         m_ov, m_gt, m_lt, m_eq, m_above, m_rise, m_fall, m_cross);
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_raw_unsigned();
        test_signed();
        test_init();
        test_hyst_debounce();
        test_no_wrap();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/comp_hyst.md
# comp_hyst

Parametrised streaming magnitude comparator with hysteresis and debounce. Each valid sample compares `a` against a threshold `b`, signed or unsigned, and produces registered raw `gt`/`lt`/`eq` flags. A three-state tracker then produces a debounced `above` level and single-cycle `rise`/`fall` crossing pulses. It sits between sample sources such as ADC front-ends or counters and control logic that needs glitch-free threshold events.

## Interface
- `WIDTH`, default 8: operand width; must be ≥ 2.
- `DEBOUNCE`, default 3: consecutive qualifying valid samples needed to change state; must be ≥ 1.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `in_valid` in, 1: `a`, `b`, `hyst` and `signed_mode` are sampled this cycle.
- `a` in, WIDTH: sample.
- `b` in, WIDTH: threshold.
- `hyst` in, WIDTH: hysteresis margin, always unsigned.
- `signed_mode` in, 1: 1 means `a` and `b` are two's complement; 0 means unsigned.
- `out_valid` out, 1: raw flags valid.
- `gt`, `lt`, `eq` out, 1 each: raw compare result, exactly one high when `out_valid` is high.
- `above` out, 1: debounced level.
- `rise`, `fall` out, 1 each: one-cycle crossing pulses.
- `cross_cnt` out, 16: crossing count (see Configuration).

## Operation
- Operand extension:
  - `a` and `b` are extended to WIDTH+2 bits: sign-extended when `signed_mode`=1, zero-extended otherwise.
  - `hyst` is zero-extended.
  - `b+hyst` and `b-hyst` are computed in WIDTH+2 bits, so they never wrap.
- Each sample is evaluated with its own `signed_mode`. A mode change does not clear the debounce counter.
- Raw compare: `gt`=a>b, `lt`=a<b, `eq`=a==b.
- Tracker states (`comp_state_e`):
  - ST_INIT: the first valid sample goes to ST_ABOVE if a>b, otherwise to ST_BELOW. `above` follows the new state. No pulse is generated and `cross_cnt` does not change.
  - ST_BELOW: the sample qualifies when a > b+hyst (strict).
  - ST_ABOVE: the sample qualifies when a < b−hyst (strict).
- Debounce counter (width $clog2(DEBOUNCE+1)):
  - A valid qualifying sample increments it.
  - A valid non-qualifying sample clears it.
  - Cycles with `in_valid`=0 hold it.
- A state change happens when a qualifying sample brings the count to DEBOUNCE. On that sample:
  - the state toggles and `above` toggles;
  - `rise` (BELOW→ABOVE) or `fall` (ABOVE→BELOW) pulses;
  - the counter clears.
- Boundary behaviour:
  - DEBOUNCE=1 switches on the first qualifying sample.
  - `hyst`=0 gives a pure strict threshold; a==b never qualifies in either state.
- Reset (asynchronous, takes effect immediately, including mid-debounce):
  - state ST_INIT, counter 0;
  - `out_valid`, `gt`, `lt`, `eq`, `above`, `rise`, `fall` all 0;
  - `cross_cnt` 0.

## Timing
- Latency is 1 cycle. A sample accepted at edge t drives `out_valid`, the raw flags, `above`, `rise`/`fall` and `cross_cnt` from edge t+1.
- `out_valid` is a registered copy of `in_valid`. Raw flags hold their last values when `out_valid`=0.
- `rise` and `fall` are high for exactly one cycle and are never high together.
- Back-to-back valid samples are accepted every cycle; there is no backpressure.

## Configuration
- `COMP_CROSS_CNT_EN` defined:
  - `cross_cnt` increments on every `rise` or `fall`;
  - it saturates at 16'hFFFF.
- Not defined: `cross_cnt` is tied to 0 and no counter logic is built.

## Structure
- Package `comp_pkg` holds:
  - typedef enum `comp_state_e` {ST_INIT, ST_BELOW, ST_ABOVE};
  - localparam `CROSS_CNT_W`=16.
- Sub-module `comp_core`: purely combinational. Takes `a`, `b`, `hyst` and `signed_mode`; returns `gt`/`lt`/`eq` and the two qualification terms, using WIDTH+2 extended arithmetic.
- `comp_hyst` contains the registers, the tracker FSM, the debounce counter and the optional crossing counter.

## Test plan
All cases use WIDTH=8 and DEBOUNCE=3.
- Raw compare, unsigned:
  - a=5, b=9 → next cycle `out_valid`=1, `lt`=1.
  - a=9, b=9 → `eq`=1.
- Signed mode:
  - a=8'hFF, b=8'h01, `signed_mode`=1 → `lt`=1.
  - Same operands with `signed_mode`=0 → `gt`=1.
- Init: first valid sample after reset, a=20, b=10 → `above`=1, `rise`=0, `cross_cnt`=0.
- Hysteresis and debounce, starting in ST_BELOW with b=100, `hyst`=4:
  - a=104 three times → no change.
  - a=105, 105, 103 → counter clears.
  - a=105 three times → `rise` high exactly one cycle after the third sample, `above`=1, `cross_cnt`=1 (macro on).
- No-wrap margins:
  - ST_BELOW, b=250, `hyst`=10, a=255 repeated → no `rise`.
  - ST_ABOVE, b=5, `hyst`=10, a=0 repeated → no `fall`.
- Gaps and reset:
  - Qualifying samples separated by `in_valid`=0 gaps still switch on the third qualifying sample.
  - After two qualifying samples, assert `rst` mid-cycle → all outputs 0 immediately.
  - After release, the first sample re-initialises the state without a pulse.
